rv32_apb_hart_arbiter: RTL and testbench

- Shares the single APB master port between NUM_HARTS per-hart CSR-side APB requesters of the barrel core.
- Removes the "one hart at a time" guarantee: any number of harts may request simultaneously.
- Grants round-robin, runs one full APB SETUP/ACCESS transfer per grant and returns read data or error to the owning hart.
- Includes a bus timeout so a hung slave cannot stall the barrel.

---
 rtl/rv32_apb_hart_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_rv32_apb_hart_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_apb_hart_arbiter.sv
// Round-robin arbiter sharing one APB master port among the barrel core's per-hart CSR requesters.
// Grant to response takes 3 cycles plus wait states; a hung slave is cut off by the ACCESS-phase timeout.
module rv32_apb_hart_arbiter #(
    parameter int NUM_HARTS      = 8,
    parameter int HART_ID_W      = $clog2(NUM_HARTS),
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_HARTS-1:0]        req_valid,
    input  logic [NUM_HARTS-1:0]        req_write,
    input  logic [NUM_HARTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_HARTS*DATA_W-1:0] req_wdata,
    output logic [NUM_HARTS-1:0]        req_ready,
    output logic [NUM_HARTS-1:0]        resp_valid,
    output logic [DATA_W-1:0]           resp_rdata,
    output logic                        resp_err,
    output logic                        busy,
    output logic [HART_ID_W-1:0]        cur_hart,
    output logic [ADDR_W-1:0]           paddr,
    output logic                        psel,
    output logic                        penable,
    output logic                        pwrite,
    output logic [DATA_W-1:0]           pwdata,
    output logic [DATA_W/8-1:0]         pstrb,
    input  logic [DATA_W-1:0]           prdata,
    input  logic                        pready,
    input  logic                        pslverr
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [NUM_HARTS-1:0] HOT0 = {{(NUM_HARTS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e                 state_q, state_d;
    logic [HART_ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [HART_ID_W-1:0]   cur_hart_q, cur_hart_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]      paddr_q, paddr_d;
    logic [DATA_W-1:0]      pwdata_q, pwdata_d;
    logic                   pwrite_q, pwrite_d;
    logic                   psel_q, psel_d;
    logic                   penable_q, penable_d;
    logic [DATA_W/8-1:0]    pstrb_q, pstrb_d;
    logic                   busy_q, busy_d;
    logic [NUM_HARTS-1:0]   resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]      resp_rdata_q, resp_rdata_d;
    logic                   resp_err_q, resp_err_d;

    logic                   gnt_found;
    logic [HART_ID_W-1:0]   gnt_idx;
    logic [HART_ID_W-1:0]   cand;

    // First requester at or after rr_ptr; index arithmetic wraps because NUM_HARTS is a power of two.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            cand = rr_ptr_q + HART_ID_W'(i);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && gnt_found && !rst)
            req_ready = HOT0 << gnt_idx;
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        cur_hart_d   = cur_hart_q;
        cnt_d        = cnt_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pwrite_d     = pwrite_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pstrb_d      = pstrb_q;
        busy_d       = busy_q;
        resp_valid_d = '0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    state_d    = SETUP;
                    cur_hart_d = gnt_idx;
                    paddr_d    = req_addr[gnt_idx*ADDR_W +: ADDR_W];
                    pwdata_d   = req_wdata[gnt_idx*DATA_W +: DATA_W];
                    pwrite_d   = req_write[gnt_idx];
                    psel_d     = 1'b1;
                    penable_d  = 1'b0;
                    pstrb_d    = '1;
                    busy_d     = 1'b1;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (pready) begin
                    state_d      = RESP;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    pstrb_d      = '0;
                    cnt_d        = '0;
                    resp_valid_d = HOT0 << cur_hart_q;
                    resp_rdata_d = pwrite_q ? '0 : prdata;
                    resp_err_d   = pslverr;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d      = RESP;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    pstrb_d      = '0;
                    cnt_d        = '0;
                    resp_valid_d = HOT0 << cur_hart_q;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                rr_ptr_d = cur_hart_q + HART_ID_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            cur_hart_q   <= '0;
            cnt_q        <= '0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pwrite_q     <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pstrb_q      <= '0;
            busy_q       <= 1'b0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cur_hart_q   <= cur_hart_d;
            cnt_q        <= cnt_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pwrite_q     <= pwrite_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pstrb_q      <= pstrb_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;
    assign cur_hart   = cur_hart_q;
    assign paddr      = paddr_q;
    assign psel       = psel_q;
    assign penable    = penable_q;
    assign pwrite     = pwrite_q;
    assign pwdata     = pwdata_q;
    assign pstrb      = pstrb_q;

endmodule

// File: tb/tb_rv32_apb_hart_arbiter.sv
// Bench for rv32_apb_hart_arbiter: directed scenarios then random traffic against a round-robin transaction model.
module tb_rv32_apb_hart_arbiter;

    localparam int N   = 8;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_valid;
    logic [DW-1:0]   resp_rdata;
    logic            resp_err;
    logic            busy;
    logic [2:0]      cur_hart;
    logic [AW-1:0]   paddr;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic [DW/8-1:0] pstrb;
    logic [DW-1:0]   prdata  = '0;
    logic            pready  = 1'b0;
    logic            pslverr = 1'b0;

    int     errors = 0;
    int     checks = 0;
    longint cyc    = 0;
    int     ptr    = 0;

    rv32_apb_hart_arbiter #(
        .NUM_HARTS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy), .cur_hart(cur_hart),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin model: first requester found scanning upward from the pointer.
    function automatic int pick(input int p, input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int h, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[h]            = 1'b1;
        req_write[h]            = w;
        req_addr[h*AW +: AW]    = a;
        req_wdata[h*DW +: DW]   = d;
    endtask

    // Entered in an IDLE cycle with requests set up; returns in the following IDLE cycle.
    task automatic xfer(input int waits, input bit serr, input logic [DW-1:0] rd, input bit tmo,
                        output int g, output int pen_cnt, output longint rcyc);
        int            exp_n;
        logic [DW-1:0] exp_rd;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic          w;
        logic [N-1:0]  oh;
        g = pick(ptr, req_valid);
        if (g < 0) g = 0;
        a  = req_addr[g*AW +: AW];
        wd = req_wdata[g*DW +: DW];
        w  = req_write[g];
        oh = '0;
        oh[g] = 1'b1;
        #1;
        chk("grant_ready", req_ready, oh);
        chk("idle_busy", busy, 0);
        tick();
        req_valid[g] = 1'b0;
        chk("setup_psel", psel, 1);
        chk("setup_penable", penable, 0);
        chk("setup_paddr", paddr, a);
        chk("setup_pwrite", pwrite, w);
        chk("setup_pwdata", pwdata, wd);
        chk("setup_pstrb", pstrb, 4'hf);
        chk("setup_cur_hart", cur_hart, g);
        chk("setup_busy", busy, 1);
        chk("setup_ready", req_ready, 0);
        tick();
        exp_n   = tmo ? TMO : waits + 1;
        pen_cnt = 0;
        for (int n = 0; n < exp_n; n++) begin
            chk("access_psel", psel, 1);
            chk("access_penable", penable, 1);
            chk("access_resp_valid", resp_valid, 0);
            pen_cnt += int'(penable);
            pready  = !tmo && (n == waits);
            prdata  = (n == waits) ? rd : DW'($urandom);
            pslverr = (n == waits) ? serr : 1'($urandom_range(0, 1));
            tick();
        end
        pready  = 1'b0;
        prdata  = DW'($urandom);
        pslverr = 1'b0;
        exp_rd  = (w || tmo) ? '0 : rd;
        rcyc    = cyc;
        chk("resp_valid", resp_valid, oh);
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_err", resp_err, tmo | serr);
        chk("resp_psel", psel, 0);
        chk("resp_penable", penable, 0);
        chk("resp_pstrb", pstrb, 0);
        ptr = (g + 1) % N;
        tick();
        chk("post_resp_valid", resp_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_rdata_hold", resp_rdata, exp_rd);
        chk("post_err_hold", resp_err, tmo | serr);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int     g;
        int     pc;
        longint rc;
        longint prev_rc;

        rst = 1'b1;
        tick();
        tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pstrb", pstrb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cur_hart", cur_hart, 0);
        rst = 1'b0;
        tick();

        // Single zero-wait read from hart 3
        set_req(3, 1'b0, 32'h0000_0010, 32'h0);
        xfer(0, 1'b0, 32'hDEAD_BEEF, 1'b0, g, pc, rc);

        // All harts write at once right after reset: grants in hart order, 4 cycles apart
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ptr = 0;
        for (int h = 0; h < N; h++)
            set_req(h, 1'b1, 32'h100 + 32'(h * 4), $urandom);
        prev_rc = 0;
        for (int k = 0; k < N; k++) begin
            xfer(0, 1'b0, 32'h0, 1'b0, g, pc, rc);
            if (k > 0) chk("burst_spacing", rc - prev_rc, 4);
            prev_rc = rc;
        end

        // Pointer wrapped after hart 7: hart 0 must win over hart 6
        set_req(0, 1'b0, $urandom, 32'h0);
        set_req(6, 1'b0, $urandom, 32'h0);
        xfer(0, 1'b0, $urandom, 1'b0, g, pc, rc);
        xfer(1, 1'b0, $urandom, 1'b0, g, pc, rc);

        // Five wait states with slave error on a read from hart 2
        set_req(2, 1'b0, 32'h0000_0200, 32'h0);
        xfer(5, 1'b1, 32'h1234_5678, 1'b0, g, pc, rc);
        chk("wait_penable_cycles", pc, 6);

        // Slave never answers: timeout after exactly TMO ACCESS cycles
        set_req(4, 1'b0, 32'h0000_0400, 32'h0);
        xfer(0, 1'b0, 32'hCAFE_F00D, 1'b1, g, pc, rc);
        chk("tmo_access_cycles", pc, TMO);

        // Reset in the third ACCESS cycle abandons the transfer
        set_req(1, 1'b0, 32'h0000_0044, 32'h0);
        #1;
        chk("rstx_ready", req_ready, 8'h02);
        tick();
        req_valid[1] = 1'b0;
        chk("rstx_setup_psel", psel, 1);
        tick();
        tick();
        tick();
        chk("rstx_access3_penable", penable, 1);
        rst = 1'b1;
        tick();
        chk("rstx_psel", psel, 0);
        chk("rstx_penable", penable, 0);
        chk("rstx_resp_valid", resp_valid, 0);
        chk("rstx_busy", busy, 0);
        chk("rstx_cur_hart", cur_hart, 0);
        rst = 1'b0;
        ptr = 0;
        tick();
        chk("rstx_no_resp", resp_valid, 0);
        set_req(5, 1'b1, 32'h0000_0500, 32'hA5A5_5A5A);
        xfer(0, 1'b0, 32'h0, 1'b0, g, pc, rc);

        // Random mixed traffic checked against the round-robin model
        for (int t = 0; t < 40; t++) begin
            for (int h = 0; h < N; h++)
                if (!req_valid[h] && $urandom_range(0, 2) == 0)
                    set_req(h, 1'($urandom_range(0, 1)), $urandom, $urandom);
            if (req_valid == '0)
                set_req(int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
            xfer(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, 1'b0, g, pc, rc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
